// File: rtl/trap_sequencer.sv
// trap_sequencer: runs the machine-mode trap-entry and MRET-return sequences
// over the single-port CSR file. While it is idle, pipeline CSR accesses pass
// straight through to the CSR file.
// Optional build macro: TRAP_VECTORED_EN adds vectored-mode interrupt
// dispatch. Without it, only direct mode is used and mtvec[1:0] is ignored.
module trap_sequencer #(
    parameter logic [11:0] MCAUSE_ADDR = 12'h342,
    parameter int          MIE_BIT     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trap_req,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic        mret_req,
    input  logic [11:0] core_csr_number,
    input  logic [1:0]  core_csr_access_type,
    input  logic [31:0] core_csr_wdata,
    output logic [31:0] core_csr_rdata,
    output logic        core_csr_ready,
    output logic [11:0] csr_number,
    output logic [1:0]  csr_access_type,
    output logic [31:0] csr_wdata,
    input  logic [31:0] csr_rdata,
    output logic        busy,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    // CSR access-type encodings shared with the CSR file
    localparam logic [1:0] CSR_READ_ONLY = 2'b00;
    localparam logic [1:0] CSR_WRITE     = 2'b01;
    localparam logic [1:0] CSR_SET       = 2'b10;
    localparam logic [1:0] CSR_CLEAR     = 2'b11;

    localparam logic [11:0] MSTATUS_ADDR = 12'h300;
    localparam logic [11:0] MTVEC_ADDR   = 12'h305;
    localparam logic [11:0] MEPC_ADDR    = 12'h341;
    localparam logic [31:0] MIE_MASK     = 32'd1 << MIE_BIT;

    typedef enum logic [2:0] {
        IDLE,
        T_EPC,
        T_CAUSE,
        T_STATUS,
        T_VEC,
        R_STATUS,
        R_EPC
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] pc_q, pc_d;
    logic        prev_mie_q, prev_mie_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] vec_base;

    // mtvec with the mode bits stripped
    assign vec_base = {csr_rdata[31:2], 2'b00};

    // State and latched-context registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            cause_q          <= '0;
            pc_q             <= '0;
            prev_mie_q       <= 1'b0;
            redirect_pc_q    <= '0;
            redirect_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            cause_q          <= cause_d;
            pc_q             <= pc_d;
            prev_mie_q       <= prev_mie_d;
            redirect_pc_q    <= redirect_pc_d;
            redirect_valid_q <= redirect_valid_d;
        end
    end

    // Next-state logic and CSR port arbitration
    always_comb begin
        state_d          = state_q;
        cause_d          = cause_q;
        pc_d             = pc_q;
        prev_mie_d       = prev_mie_q;
        redirect_pc_d    = redirect_pc_q;
        redirect_valid_d = 1'b0;
        csr_number       = 12'h000;
        csr_access_type  = CSR_READ_ONLY;
        csr_wdata        = 32'h0;
        core_csr_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                if (trap_req) begin
                    // trap wins; a simultaneous mret is dropped and the
                    // pipeline access is held off
                    cause_d = trap_cause;
                    pc_d    = trap_pc;
                    state_d = T_EPC;
                end else if (mret_req) begin
                    state_d = R_STATUS;
                end else begin
                    csr_number      = core_csr_number;
                    csr_access_type = core_csr_access_type;
                    csr_wdata       = core_csr_wdata;
                    core_csr_ready  = 1'b1;
                end
            end
            T_EPC: begin
                csr_number      = MEPC_ADDR;
                csr_access_type = CSR_WRITE;
                csr_wdata       = pc_q;
                state_d         = T_CAUSE;
            end
            T_CAUSE: begin
                csr_number      = MCAUSE_ADDR;
                csr_access_type = CSR_WRITE;
                csr_wdata       = cause_q;
                state_d         = T_STATUS;
            end
            T_STATUS: begin
                // read the old MIE while clearing it in the same access
                csr_number      = MSTATUS_ADDR;
                csr_access_type = CSR_CLEAR;
                csr_wdata       = MIE_MASK;
                prev_mie_d      = csr_rdata[MIE_BIT];
                state_d         = T_VEC;
            end
            T_VEC: begin
                csr_number       = MTVEC_ADDR;
                redirect_pc_d    = vec_base;
`ifdef TRAP_VECTORED_EN
                if (csr_rdata[1:0] == 2'b01 && cause_q[31])
                    redirect_pc_d = vec_base + {cause_q[29:0], 2'b00};
`endif
                redirect_valid_d = 1'b1;
                state_d          = IDLE;
            end
            R_STATUS: begin
                if (prev_mie_q) begin
                    csr_number      = MSTATUS_ADDR;
                    csr_access_type = CSR_SET;
                    csr_wdata       = MIE_MASK;
                end
                state_d = R_EPC;
            end
            R_EPC: begin
                csr_number       = MEPC_ADDR;
                redirect_pc_d    = csr_rdata;
                redirect_valid_d = 1'b1;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // reset aborts at once: the port goes quiet in the reset cycle itself
        if (reset) begin
            csr_number      = 12'h000;
            csr_access_type = CSR_READ_ONLY;
            csr_wdata       = 32'h0;
            core_csr_ready  = 1'b0;
        end
    end

    assign core_csr_rdata = csr_rdata;
    assign busy           = (state_q != IDLE);
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed bench for trap_sequencer with a small CSR file
// model (mstatus, mtvec, mepc, mcause) behind the sequencer's CSR port.
module tb_trap_sequencer;

    localparam logic [1:0] RO = 2'b00;
    localparam logic [1:0] WR = 2'b01;
    localparam logic [1:0] ST = 2'b10;
    localparam logic [1:0] CL = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trap_req = 1'b0;
    logic [31:0] trap_cause = '0;
    logic [31:0] trap_pc = '0;
    logic        mret_req = 1'b0;
    logic [11:0] core_csr_number = '0;
    logic [1:0]  core_csr_access_type = '0;
    logic [31:0] core_csr_wdata = '0;
    logic [31:0] core_csr_rdata;
    logic        core_csr_ready;
    logic [11:0] csr_number;
    logic [1:0]  csr_access_type;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int total = 0;
    int passed = 0;

    trap_sequencer dut (
        .clk                  (clk),
        .reset                (reset),
        .trap_req             (trap_req),
        .trap_cause           (trap_cause),
        .trap_pc              (trap_pc),
        .mret_req             (mret_req),
        .core_csr_number      (core_csr_number),
        .core_csr_access_type (core_csr_access_type),
        .core_csr_wdata       (core_csr_wdata),
        .core_csr_rdata       (core_csr_rdata),
        .core_csr_ready       (core_csr_ready),
        .csr_number           (csr_number),
        .csr_access_type      (csr_access_type),
        .csr_wdata            (csr_wdata),
        .csr_rdata            (csr_rdata),
        .busy                 (busy),
        .redirect_valid       (redirect_valid),
        .redirect_pc          (redirect_pc)
    );

    always #5 clk = ~clk;

    // CSR file model: not reset, so state survives a sequencer reset
    logic [31:0] mstatus_m = 32'h0;
    logic [31:0] mtvec_m   = 32'h0;
    logic [31:0] mepc_m    = 32'h0;
    logic [31:0] mcause_m  = 32'h0;

    function automatic logic [31:0] apply(logic [31:0] old, logic [1:0] t, logic [31:0] d);
        case (t)
            WR:      return d;
            ST:      return old | d;
            CL:      return old & ~d;
            default: return old;
        endcase
    endfunction

    always @(posedge clk) begin
        case (csr_number)
            12'h300: mstatus_m <= apply(mstatus_m, csr_access_type, csr_wdata);
            12'h305: mtvec_m   <= apply(mtvec_m, csr_access_type, csr_wdata);
            12'h341: mepc_m    <= apply(mepc_m, csr_access_type, csr_wdata);
            12'h342: mcause_m  <= apply(mcause_m, csr_access_type, csr_wdata);
            default: ;
        endcase
    end

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_number)
            12'h300: csr_rdata = mstatus_m;
            12'h305: csr_rdata = mtvec_m;
            12'h341: csr_rdata = mepc_m;
            12'h342: csr_rdata = mcause_m;
            default: csr_rdata = 32'h0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        else
            passed++;
    endtask

    task automatic drive(input logic t, input logic m, input logic [31:0] c, input logic [31:0] p,
                         input logic [11:0] n, input logic [1:0] ty, input logic [31:0] w);
        trap_req = t; mret_req = m; trap_cause = c; trap_pc = p;
        core_csr_number = n; core_csr_access_type = ty; core_csr_wdata = w;
    endtask

    // waits (bounded) for redirect_valid, counting negedges since the request cycle
    task automatic wait_rv(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            drive(1'b0, 1'b0, 32'h0, 32'h0, 12'h0, RO, 32'h0);
            #1;
            cnt++;
        end while (!redirect_valid && cnt < 12);
    endtask

    typedef struct {
        logic        trap;
        logic        mret;
        logic [31:0] cause;
        logic [31:0] pc;
        logic [11:0] cnum;
        logic [1:0]  ctype;
        logic [31:0] cwdata;
        logic [11:0] e_num;
        logic [1:0]  e_type;
        logic [31:0] e_wdata;
        logic        e_ready;
        logic        e_busy;
        logic        e_rv;
        logic        chk_rd;
        logic [31:0] e_rd;
        logic        chk_pc;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int n;

        // one row per cycle: pass-through, trap entry, then MRET
        vecs[0]  = '{0,0,0,0,    12'h305,WR,32'h100, 12'h305,WR,32'h100, 1,0,0, 0,0,     0,0};
        vecs[1]  = '{0,0,0,0,    12'h305,RO,0,       12'h305,RO,0,       1,0,0, 1,32'h100,0,0};
        vecs[2]  = '{0,0,0,0,    12'h300,WR,32'h8,   12'h300,WR,32'h8,   1,0,0, 0,0,     0,0};
        vecs[3]  = '{1,0,2,32'h80,12'h000,RO,0,      12'h000,RO,0,       0,0,0, 0,0,     0,0};
        vecs[4]  = '{0,0,0,0,    12'h000,RO,0,       12'h341,WR,32'h80,  0,1,0, 0,0,     0,0};
        vecs[5]  = '{0,0,0,0,    12'h000,RO,0,       12'h342,WR,32'h2,   0,1,0, 0,0,     0,0};
        vecs[6]  = '{0,0,0,0,    12'h000,RO,0,       12'h300,CL,32'h8,   0,1,0, 1,32'h8, 0,0};
        vecs[7]  = '{0,0,0,0,    12'h000,RO,0,       12'h305,RO,0,       0,1,0, 1,32'h100,0,0};
        vecs[8]  = '{0,0,0,0,    12'h300,RO,0,       12'h300,RO,0,       1,0,1, 1,32'h0, 1,32'h100};
        vecs[9]  = '{0,1,0,0,    12'h000,RO,0,       12'h000,RO,0,       0,0,0, 0,0,     1,32'h100};
        vecs[10] = '{0,0,0,0,    12'h000,RO,0,       12'h300,ST,32'h8,   0,1,0, 0,0,     1,32'h100};
        vecs[11] = '{0,0,0,0,    12'h000,RO,0,       12'h341,RO,0,       0,1,0, 1,32'h80, 1,32'h100};
        vecs[12] = '{0,0,0,0,    12'h300,RO,0,       12'h300,RO,0,       1,0,1, 1,32'h8, 1,32'h80};

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset busy", {31'b0, busy}, 32'h0);
        chk("reset redirect_valid", {31'b0, redirect_valid}, 32'h0);
        chk("reset redirect_pc", redirect_pc, 32'h0);
        chk("reset ready", {31'b0, core_csr_ready}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // table-driven cycle script
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].trap, vecs[i].mret, vecs[i].cause, vecs[i].pc,
                  vecs[i].cnum, vecs[i].ctype, vecs[i].cwdata);
            #1;
            chk($sformatf("row%0d csr_number", i), {20'b0, csr_number}, {20'b0, vecs[i].e_num});
            chk($sformatf("row%0d csr_access_type", i), {30'b0, csr_access_type}, {30'b0, vecs[i].e_type});
            chk($sformatf("row%0d csr_wdata", i), csr_wdata, vecs[i].e_wdata);
            chk($sformatf("row%0d ready", i), {31'b0, core_csr_ready}, {31'b0, vecs[i].e_ready});
            chk($sformatf("row%0d busy", i), {31'b0, busy}, {31'b0, vecs[i].e_busy});
            chk($sformatf("row%0d redirect_valid", i), {31'b0, redirect_valid}, {31'b0, vecs[i].e_rv});
            if (vecs[i].chk_rd)
                chk($sformatf("row%0d core_csr_rdata", i), core_csr_rdata, vecs[i].e_rd);
            if (vecs[i].chk_pc)
                chk($sformatf("row%0d redirect_pc", i), redirect_pc, vecs[i].e_pc);
            $display("row %0d: num=%03h type=%0d wdata=%08h ready=%0b busy=%0b rv=%0b pc=%08h",
                     i, csr_number, csr_access_type, csr_wdata, core_csr_ready, busy,
                     redirect_valid, redirect_pc);
            @(negedge clk);
        end

        // simultaneous trap + mret + core write; requests during busy ignored
        drive(1'b1, 1'b1, 32'h5, 32'h44, 12'h305, WR, 32'h200);
        #1;
        chk("simul ready", {31'b0, core_csr_ready}, 32'h0);
        chk("simul type", {30'b0, csr_access_type}, {30'b0, RO});
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h9, 32'h99, 12'h000, RO, 32'h0);
        #1;
        chk("simul epc wdata", csr_wdata, 32'h44);
        wait_rv(n);
        chk("simul latency", n, 4);
        chk("simul redirect_pc", redirect_pc, 32'h100);
        chk("simul mtvec untouched", mtvec_m, 32'h100);
        chk("simul mcause", mcause_m, 32'h5);
        chk("simul mepc", mepc_m, 32'h44);
        $display("simul trap: latency=%0d pc=%08h mcause=%08h", n + 1, redirect_pc, mcause_m);

        // mret issued in the redirect cycle is accepted
        drive(1'b0, 1'b1, 32'h0, 32'h0, 12'h000, RO, 32'h0);
        #1;
        chk("mret in rv cycle ready", {31'b0, core_csr_ready}, 32'h0);
        wait_rv(n);
        chk("mret latency", n, 3);
        chk("mret redirect_pc", redirect_pc, 32'h44);
        chk("mret mstatus", mstatus_m, 32'h8);
        $display("mret: latency=%0d pc=%08h mstatus=%08h", n, redirect_pc, mstatus_m);

        // reset during T_CAUSE
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h3, 32'h80, 12'h000, RO, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 12'h000, RO, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst T_CAUSE type", {30'b0, csr_access_type}, {30'b0, RO});
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst busy", {31'b0, busy}, 32'h0);
        chk("rst redirect_valid", {31'b0, redirect_valid}, 32'h0);
        chk("rst redirect_pc", redirect_pc, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst mcause kept", mcause_m, 32'h5);
        chk("rst mstatus kept", mstatus_m, 32'h8);
        chk("rst mepc", mepc_m, 32'h80);
        chk("rst idle ready", {31'b0, core_csr_ready}, 32'h1);
        $display("reset mid-trap: busy=%0b mcause=%08h mstatus=%08h", busy, mcause_m, mstatus_m);

        // vectored interrupt dispatch
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 12'h305, WR, 32'h101);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h8000_0007, 32'h10, 12'h000, RO, 32'h0);
        wait_rv(n);
        chk("vec latency", n, 5);
`ifdef TRAP_VECTORED_EN
        chk("vec interrupt pc", redirect_pc, 32'h11C);
`else
        chk("vec interrupt pc", redirect_pc, 32'h100);
`endif
        $display("vectored interrupt: pc=%08h", redirect_pc);

        // back-to-back trap (exception cause, MIE already 0), then mret
        drive(1'b1, 1'b0, 32'h2, 32'h20, 12'h000, RO, 32'h0);
        wait_rv(n);
        chk("b2b latency", n, 5);
        chk("b2b exception pc", redirect_pc, 32'h100);
        drive(1'b0, 1'b1, 32'h0, 32'h0, 12'h000, RO, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 12'h000, RO, 32'h0);
        #1;
        chk("b2b R_STATUS type", {30'b0, csr_access_type}, {30'b0, RO});
        wait_rv(n);
        chk("b2b mret pc", redirect_pc, 32'h20);
        chk("b2b mstatus", mstatus_m, 32'h0);
        $display("back-to-back: mret pc=%08h mstatus=%08h", redirect_pc, mstatus_m);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
Sequences machine-mode trap entry and MRET return over the single-port CSR file: it drives the CSR number, access type and write-data lines, and reads the CSR read-data line.
- While idle, it passes the pipeline's CSR-instruction accesses straight through to the CSR file.
- On a trap or MRET, it takes the CSR port for a fixed multi-cycle sequence and ends by issuing a PC redirect to the fetch stage.

Parameters:
- MCAUSE_ADDR, 12'h342, CSR number of mcause (added to the CSR file alongside this block).
- MIE_BIT, 3, bit position of mstatus.MIE.

Ports:
- clk  input  1  clock
- reset  input  1  reset
- trap_req  input  1  one-cycle trap request pulse; sampled only in IDLE
- trap_cause  input  32  mcause value; bit 31 = interrupt
- trap_pc  input  32  PC of the faulting instruction, written to mepc
- mret_req  input  1  one-cycle MRET request pulse; sampled only in IDLE
- core_csr_number  input  12  pipeline CSR number
- core_csr_access_type  input  2  pipeline access type (csr.h encodings)
- core_csr_wdata  input  32  pipeline CSR operand
- core_csr_rdata  output  32  equals csr_rdata
- core_csr_ready  output  1  pipeline access takes effect this cycle
- csr_number  output  12  to CSR file
- csr_access_type  output  2  to CSR file
- csr_wdata  output  32  to CSR file
- csr_rdata  input  32  from CSR file; combinational on csr_number
- busy  output  1  sequence in progress
- redirect_valid  output  1  one-cycle pulse; redirect_pc is valid
- redirect_pc  output  32  new fetch PC

Behaviour:
- Reset is synchronous and active-high, on reset, with clock clk.
- Reset values: state = IDLE; busy, redirect_valid = 0; redirect_pc = 0; latched cause, pc and prev_mie = 0. Reset mid-sequence aborts immediately; no further CSR writes occur.
- Outside the pass-through case, the CSR port defaults to CSR_READ_ONLY, number 0, wdata 0.
- States: IDLE, T_EPC, T_CAUSE, T_STATUS, T_VEC, R_STATUS, R_EPC.
- IDLE, no request:
  - csr_* = core_csr_* combinationally; core_csr_ready = 1.
- IDLE, trap_req = 1:
  - Latch trap_cause and trap_pc; go to T_EPC.
  - Port is forced to CSR_READ_ONLY this cycle; core_csr_ready = 0, so the pipeline access does not take effect.
  - trap_req wins over a simultaneous mret_req; that mret_req is dropped.
- IDLE, mret_req = 1 (no trap_req): go to R_STATUS; core_csr_ready = 0.
- T_EPC: CSR_WRITE MEPC (12'h341) with the latched pc.
- T_CAUSE: CSR_WRITE MCAUSE_ADDR with the latched cause.
- T_STATUS: CSR_CLEAR MSTATUS (12'h300) with wdata = 1<<MIE_BIT; prev_mie <= csr_rdata[MIE_BIT].
- T_VEC: CSR_READ_ONLY MTVEC (12'h305); redirect_pc <= {csr_rdata[31:2], 2'b00}; redirect_valid <= 1; go to IDLE.
- R_STATUS:
  - prev_mie = 1: CSR_SET MSTATUS, wdata = 1<<MIE_BIT.
  - prev_mie = 0: CSR_READ_ONLY.
- R_EPC: CSR_READ_ONLY MEPC; redirect_pc <= csr_rdata; redirect_valid <= 1; go to IDLE.
- Latency:
  - Trap: request cycle + 4 sequence cycles; redirect_valid is high in the cycle after T_VEC, i.e. 5 cycles after the trap_req edge.
  - MRET: redirect_valid is high 3 cycles after the mret_req edge.
- redirect_valid is high for exactly 1 cycle, coinciding with the first IDLE cycle; redirect_pc holds its value until the next redirect.
- busy = 1 in every non-IDLE state. core_csr_ready = 0 whenever busy.
- trap_req or mret_req asserted while busy is ignored.
- A request in the IDLE cycle that carries redirect_valid is accepted normally.
- Back-to-back traps re-enter cleanly: prev_mie is overwritten with the current mstatus.MIE, which is 0 after the first trap.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined: in T_VEC, if csr_rdata[1:0] == 2'b01 and the latched cause[31] == 1, redirect_pc = {csr_rdata[31:2], 2'b00} + (cause[30:0] << 2), computed 32-bit with wrap-around. All other cases use direct mode.
- Undefined: direct mode only; mtvec[1:0] is ignored.

Test Plan:
- Pass-through: idle, core CSR_WRITE MTVEC 32'h0000_0100 → csr_* mirrors the core inputs, core_csr_ready = 1; a following read returns 32'h100.
- Trap entry: mstatus = 32'h8, mtvec = 32'h100, trap_req with cause 2, pc 32'h80 → cycle by cycle:
  - MEPC write 32'h80;
  - MCAUSE write 2;
  - MSTATUS clear 8, after which mstatus = 0;
  - redirect_valid with redirect_pc = 32'h100 five cycles after the request;
  - busy high for 4 cycles.
- MRET after that trap: mret_req → MSTATUS set 8 (mstatus = 8); redirect_pc = 32'h80 three cycles later.
- Simultaneous requests: trap_req, mret_req and a core CSR write in the same IDLE cycle → trap sequence only; core_csr_ready = 0; the core write has no effect; requests during busy are ignored.
- Reset mid-trap: assert reset during T_CAUSE → next cycle IDLE, busy = 0, redirect_valid = 0, no MCAUSE/MSTATUS writes; mepc keeps 32'h80 unless the CSR file is also reset.
- TRAP_VECTORED_EN: mtvec = 32'h101, cause 32'h8000_0007 → redirect_pc = 32'h11C. Without the macro → 32'h100.
